// File: rtl/delayline_arbiter.sv
// Round-robin arbiter feeding a shared fixed-latency tagged delay pipeline with per-channel
// in-flight limits. Define DELAYLINE_ARBITER_STATS_EN to add per-channel grant counters.
module delayline_arbiter #(
  parameter int unsigned WIDTH    = 19,
  parameter int unsigned LATENCY  = 2,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned MAX_OUT  = 2,
  localparam int unsigned ChanW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int unsigned CntW    = $clog2(MAX_OUT + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       req_valid,
  input  logic [CHANNELS*WIDTH-1:0] req_data,
  output logic [CHANNELS-1:0]       req_ready,
  output logic                      out_valid,
  output logic [ChanW-1:0]          out_chan,
  output logic [WIDTH-1:0]          out_data,
`ifdef DELAYLINE_ARBITER_STATS_EN
  output logic [CHANNELS*16-1:0]    stat_grants,
`endif
  output logic                      busy
);

  logic [ChanW-1:0]   ptr_q, ptr_d;
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [ChanW-1:0]   chan_q [LATENCY];
  logic [ChanW-1:0]   chan_d [LATENCY];
  logic [WIDTH-1:0]   data_q [LATENCY];
  logic [WIDTH-1:0]   data_d [LATENCY];
  logic [CntW-1:0]    cnt_q  [CHANNELS];
  logic [CntW-1:0]    cnt_d  [CHANNELS];

  logic [CHANNELS-1:0] retire, eligible, grant;
  logic [ChanW-1:0]    gnt_idx, idx;
  logic                found;

  assign out_valid = vld_q[LATENCY-1];
  assign out_chan  = chan_q[LATENCY-1];
  assign out_data  = data_q[LATENCY-1];
  assign busy      = |vld_q;

  always_comb begin
    retire   = '0;
    eligible = '0;
    grant    = '0;
    gnt_idx  = '0;
    idx      = '0;
    found    = 1'b0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      retire[k] = out_valid && (out_chan == ChanW'(k));
      // A word retiring this cycle frees its slot for an accept in the same cycle.
      eligible[k] = req_valid[k] && (retire[k] || (cnt_q[k] < CntW'(MAX_OUT)));
    end
    for (int unsigned i = 1; i <= CHANNELS; i++) begin
      idx = ChanW'((32'(ptr_q) + i) % CHANNELS);
      if (!found && eligible[idx]) begin
        found        = 1'b1;
        grant[idx]   = 1'b1;
        gnt_idx      = idx;
      end
    end
    req_ready = reset ? '0 : grant;
  end

  always_comb begin
    ptr_d     = found ? gnt_idx : ptr_q;
    vld_d     = '0;
    vld_d[0]  = found;
    chan_d[0] = gnt_idx;
    data_d[0] = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (grant[k]) data_d[0] = req_data[k*WIDTH +: WIDTH];
    end
    for (int unsigned s = 1; s < LATENCY; s++) begin
      vld_d[s]  = vld_q[s-1];
      chan_d[s] = chan_q[s-1];
      data_d[s] = data_q[s-1];
    end
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      cnt_d[k] = cnt_q[k];
      if (grant[k] && !retire[k])      cnt_d[k] = cnt_q[k] + CntW'(1);
      else if (!grant[k] && retire[k]) cnt_d[k] = cnt_q[k] - CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= ChanW'(CHANNELS - 1);
      vld_q <= '0;
      for (int unsigned s = 0; s < LATENCY; s++) begin
        chan_q[s] <= '0;
        data_q[s] <= '0;
      end
      for (int unsigned k = 0; k < CHANNELS; k++) cnt_q[k] <= '0;
    end else begin
      ptr_q <= ptr_d;
      vld_q <= vld_d;
      for (int unsigned s = 0; s < LATENCY; s++) begin
        chan_q[s] <= chan_d[s];
        data_q[s] <= data_d[s];
      end
      for (int unsigned k = 0; k < CHANNELS; k++) cnt_q[k] <= cnt_d[k];
    end
  end

`ifdef DELAYLINE_ARBITER_STATS_EN
  logic [15:0] stat_q [CHANNELS];
  logic [15:0] stat_d [CHANNELS];

  always_comb begin
    stat_grants = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      stat_d[k] = (grant[k] && (stat_q[k] != 16'hFFFF)) ? stat_q[k] + 16'd1 : stat_q[k];
      stat_grants[k*16 +: 16] = stat_q[k];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < CHANNELS; k++) stat_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < CHANNELS; k++) stat_q[k] <= stat_d[k];
    end
  end
`endif

endmodule

// File: tb/tb_delayline_arbiter.sv
// Directed self-checking bench: default instance (LATENCY=2, MAX_OUT=2) plus a
// LATENCY=4, MAX_OUT=1 instance for the in-flight limit scenario.
module tb_delayline_arbiter;
  localparam int W = 19;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [3:0]    rv, rr, rv_b, rr_b;
  logic [4*W-1:0] rd, rd_b;
  logic          ov, bs, ov_b, bs_b;
  logic [1:0]    oc, oc_b;
  logic [W-1:0]  od, od_b;
`ifdef DELAYLINE_ARBITER_STATS_EN
  logic [63:0]   sg, sg_b;
`endif

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  delayline_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(rv), .req_data(rd), .req_ready(rr),
    .out_valid(ov), .out_chan(oc), .out_data(od),
`ifdef DELAYLINE_ARBITER_STATS_EN
    .stat_grants(sg),
`endif
    .busy(bs)
  );

  delayline_arbiter #(.WIDTH(19), .LATENCY(4), .CHANNELS(4), .MAX_OUT(1)) dut_b (
    .clk(clk), .reset(reset), .req_valid(rv_b), .req_data(rd_b), .req_ready(rr_b),
    .out_valid(ov_b), .out_chan(oc_b), .out_data(od_b),
`ifdef DELAYLINE_ARBITER_STATS_EN
    .stat_grants(sg_b),
`endif
    .busy(bs_b)
  );

  task automatic do_reset();
    rv = '0; rv_b = '0; rd = '0; rd_b = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; rv = 4'b1111; rd = '1;
    #1;
    checks++; if (rr !== 4'b0000) $display("FAIL reset_ready got %b want 0000", rr); else passed++;
    checks++; if (ov !== 1'b0) $display("FAIL reset_out_valid got %b want 0", ov); else passed++;
    checks++; if (oc !== 2'd0 || od !== '0)
      $display("FAIL reset_out_fields got chan=%0d data=%h want 0/0", oc, od); else passed++;
    checks++; if (bs !== 1'b0) $display("FAIL reset_busy got %b want 0", bs); else passed++;
    @(negedge clk);
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    rv = 4'b0100; rd[2*W +: W] = 19'h12345;
    #1;
    checks++; if (rr !== 4'b0100) $display("FAIL single_ready got %b want 0100", rr); else passed++;
    @(negedge clk); rv = '0; rd = '0; #1;
    checks++; if (ov !== 1'b0 || bs !== 1'b1)
      $display("FAIL single_c1 got valid=%b busy=%b want 0/1", ov, bs); else passed++;
    @(negedge clk); #1;
    checks++; if (ov !== 1'b1 || oc !== 2'd2 || od !== 19'h12345 || bs !== 1'b1)
      $display("FAIL single_out got v=%b c=%0d d=%h b=%b want 1/2/12345/1", ov, oc, od, bs);
    else passed++;
    @(negedge clk); #1;
    checks++; if (ov !== 1'b0 || bs !== 1'b0)
      $display("FAIL single_after got valid=%b busy=%b want 0/0", ov, bs); else passed++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rr;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      rv = (i < 8) ? 4'b1111 : 4'b0000;
      for (int k = 0; k < 4; k++) rd[k*W +: W] = 19'(i * 16 + k);
      #1;
      exp_rr = (i < 8) ? 4'(1 << (i % 4)) : 4'b0000;
      checks++; if (rr !== exp_rr) $display("FAIL rr_grant[%0d] got %b want %b", i, rr, exp_rr);
      else passed++;
      if (i >= 2) begin
        checks++;
        if (ov !== 1'b1 || oc !== 2'((i - 2) % 4) || od !== 19'((i - 2) * 16 + (i - 2) % 4))
          $display("FAIL rr_out[%0d] got v=%b c=%0d d=%h want 1/%0d/%h", i, ov, oc, od,
                   (i - 2) % 4, (i - 2) * 16 + (i - 2) % 4);
        else passed++;
      end
      @(negedge clk);
    end
    #1;
    checks++; if (ov !== 1'b0 || bs !== 1'b0)
      $display("FAIL rr_drain got valid=%b busy=%b want 0/0", ov, bs); else passed++;
  endtask

  task automatic test_skip();
    logic [3:0] exp_seq [3];
    exp_seq[0] = 4'b0010; exp_seq[1] = 4'b1000; exp_seq[2] = 4'b0010;
    do_reset();
    rv = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (rr !== exp_seq[i]) $display("FAIL skip[%0d] got %b want %b", i, rr, exp_seq[i]);
      else passed++;
      @(negedge clk);
    end
    rv = '0;
  endtask

  task automatic test_limit();
    do_reset();
    rv_b = 4'b0010;
    for (int i = 0; i < 12; i++) begin
      rd_b[1*W +: W] = 19'(32'h200 + i);
      #1;
      checks++;
      if (rr_b !== ((i % 4 == 0) ? 4'b0010 : 4'b0000))
        $display("FAIL limit_ready[%0d] got %b want %b", i, rr_b,
                 (i % 4 == 0) ? 4'b0010 : 4'b0000);
      else passed++;
      checks++;
      if (ov_b !== (i >= 4 && i % 4 == 0))
        $display("FAIL limit_valid[%0d] got %b want %b", i, ov_b, (i >= 4 && i % 4 == 0));
      else passed++;
      if (i >= 4 && i % 4 == 0) begin
        checks++;
        if (oc_b !== 2'd1 || od_b !== 19'(32'h200 + i - 4))
          $display("FAIL limit_out[%0d] got c=%0d d=%h want 1/%h", i, oc_b, od_b, 32'h200 + i - 4);
        else passed++;
      end
      @(negedge clk);
    end
    rv_b = '0;
  endtask

  task automatic test_accept_retire();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      rv = (i < 8) ? 4'b0001 : 4'b0000;
      rd[0 +: W] = 19'(32'h70000 + i);
      #1;
      checks++;
      if (rr !== ((i < 8) ? 4'b0001 : 4'b0000))
        $display("FAIL ar_ready[%0d] got %b want %b", i, rr, (i < 8) ? 4'b0001 : 4'b0000);
      else passed++;
      if (i >= 2) begin
        checks++;
        if (ov !== 1'b1 || oc !== 2'd0 || od !== 19'(32'h70000 + i - 2))
          $display("FAIL ar_out[%0d] got v=%b c=%0d d=%h want 1/0/%h", i, ov, oc, od,
                   32'h70000 + i - 2);
        else passed++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    rv = 4'b0001; rd[0 +: W] = 19'h00AAA; #1;
    checks++; if (rr !== 4'b0001) $display("FAIL mid_acc0 got %b want 0001", rr); else passed++;
    @(negedge clk);
    rv = 4'b0010; rd[1*W +: W] = 19'h00BBB; #1;
    checks++; if (rr !== 4'b0010) $display("FAIL mid_acc1 got %b want 0010", rr); else passed++;
    @(negedge clk);
    rv = '0; #1;
    checks++; if (ov !== 1'b1 || bs !== 1'b1)
      $display("FAIL mid_inflight got valid=%b busy=%b want 1/1", ov, bs); else passed++;
    reset = 1'b1; #1;
    checks++; if (ov !== 1'b0 || bs !== 1'b0 || rr !== 4'b0000)
      $display("FAIL mid_async got v=%b b=%b r=%b want 0/0/0000", ov, bs, rr); else passed++;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (ov !== 1'b0 || bs !== 1'b0)
        $display("FAIL mid_quiet[%0d] got valid=%b busy=%b want 0/0", i, ov, bs); else passed++;
      @(negedge clk);
    end
    rv = 4'b1001; #1;
    checks++; if (rr !== 4'b0001) $display("FAIL mid_ptr0 got %b want 0001", rr); else passed++;
    @(negedge clk); #1;
    checks++; if (rr !== 4'b1000) $display("FAIL mid_ptr1 got %b want 1000", rr); else passed++;
    @(negedge clk);
    rv = '0;
  endtask

`ifdef DELAYLINE_ARBITER_STATS_EN
  task automatic test_stats();
    do_reset();
    rv = 4'b0100;
    repeat (70000) @(negedge clk);
    rv = '0; #1;
    checks++; if (sg !== {16'h0000, 16'hFFFF, 16'h0000, 16'h0000})
      $display("FAIL stats got %h want 0000ffff00000000", sg); else passed++;
  endtask
`endif

  initial begin
    rv = '0; rv_b = '0; rd = '0; rd_b = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_skip();
    test_limit();
    test_accept_retire();
    test_reset_midflight();
`ifdef DELAYLINE_ARBITER_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
